// File: rtl/exe_mem_pkg.sv
// Shared pipeline definitions for the EXE/MEM register and neighbouring stage registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: control field widths, FP sequencing state enum, MEM-side bus struct, bubble helper.
package exe_mem_pkg;

    localparam int WB_W  = 10;
    localparam int MEM_W = 3;

    localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;
    localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        FP_BUSY = 1'b1
    } fp_state_e;

    // Everything registered at the EXE/MEM boundary, in one word.
    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [31:0]      pc;
        logic [31:0]      result;
        logic [31:0]      store_data;
        logic [4:0]       dst;
        logic             fp;
        logic             valid;
    } mem_bus_t;

    // A bubble still carries the PC so exception/debug logic downstream sees where it came from.
    function automatic mem_bus_t make_bubble(input logic [31:0] pc);
        mem_bus_t b;
        b        = '0;
        b.wb     = WB_BUBBLE;
        b.mem    = MEM_BUBBLE;
        b.pc     = pc;
        return b;
    endfunction

endpackage

// File: rtl/exe_mem_if.sv
// Signal bundle between ID_EXE / EXE units and the EXE/MEM register.
// Latency: n/a (wires only).
// Backpressure: mem_stall in, stall_EXE out.
// slave = the exe_mem stage; master = whatever drives the EXE side and observes MEM.
interface exe_mem_if;
    import exe_mem_pkg::*;

    logic              valid_EXE;
    logic [WB_W-1:0]   WB_control_EXE;
    logic [MEM_W-1:0]  MEM_control_EXE;
    logic              FP_EXE;
    logic [31:0]       PC_EXE;
    logic [31:0]       ALU_result;
    logic [31:0]       FP_result;
    logic [31:0]       Store_data;
    logic [4:0]        Dst_reg;
    logic              mem_stall;
    logic              flush;

    logic [WB_W-1:0]   WB_control_MEM;
    logic [MEM_W-1:0]  MEM_control_MEM;
    logic [31:0]       PC_MEM;
    logic [31:0]       Result_MEM;
    logic [31:0]       Store_data_MEM;
    logic [4:0]        Dst_reg_MEM;
    logic              FP_MEM;
    logic              valid_MEM;
    logic              stall_EXE;

    modport slave (
        input  valid_EXE, WB_control_EXE, MEM_control_EXE, FP_EXE, PC_EXE,
               ALU_result, FP_result, Store_data, Dst_reg, mem_stall, flush,
        output WB_control_MEM, MEM_control_MEM, PC_MEM, Result_MEM,
               Store_data_MEM, Dst_reg_MEM, FP_MEM, valid_MEM, stall_EXE
    );

    modport master (
        output valid_EXE, WB_control_EXE, MEM_control_EXE, FP_EXE, PC_EXE,
               ALU_result, FP_result, Store_data, Dst_reg, mem_stall, flush,
        input  WB_control_MEM, MEM_control_MEM, PC_MEM, Result_MEM,
               Store_data_MEM, Dst_reg_MEM, FP_MEM, valid_MEM, stall_EXE
    );

endinterface

// File: rtl/exe_mem_fp_busy_ctr.sv
// Multi-cycle FP occupancy counter: tracks how long an FP op has been sitting in EXE.
// Latency: start -> done after FP_LAT-1 edges; done is combinational on cnt==0.
// Backpressure: counts down through mem_stall, holds at 0 until mem_stall drops; flush aborts.
// Ports: Clk/Rst, start_i (FP op arriving in IDLE), flush_i, mem_stall_i,
//        busy_o (in FP_BUSY), done_o (capture FP result this edge), stall_req_o (hold EXE).
module exe_mem_fp_busy_ctr
    import exe_mem_pkg::*;
#(
    parameter int FP_LAT = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic start_i,
    input  logic flush_i,
    input  logic mem_stall_i,
    output logic busy_o,
    output logic done_o,
    output logic stall_req_o
);

    // The issue cycle is one of the FP_LAT cycles, and the final cnt==0 cycle is another.
    localparam logic [3:0] CNT_INIT = (FP_LAT > 1) ? 4'(FP_LAT - 2) : 4'd0;

    fp_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = FP_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            FP_BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!mem_stall_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        stall_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_req_o = start_i && !flush_i;
            end
            FP_BUSY: begin
                busy_o      = 1'b1;
                done_o      = (cnt_q == 4'd0) && !flush_i && !mem_stall_i;
                // A flushed op frees EXE at once; only mem_stall can still hold it.
                stall_req_o = !flush_i && !done_o;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exe_mem.sv
// EXE/MEM pipeline register with multi-cycle FP sequencing, bubble insertion and flush.
// Latency: integer op 1 edge; FP op lands at MEM on the FP_LAT-th edge after FP_LAT-1 bubbles.
// Backpressure: mem_stall holds all MEM outputs; stall_EXE (comb) holds ID_EXE and earlier.
// Ports: Clk, Rst (async, active-high), bus (exe_mem_if.slave: EXE-side inputs, MEM-side outputs).
module exe_mem
    import exe_mem_pkg::*;
#(
    parameter int FP_LAT = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    exe_mem_if.slave   bus
);

    if (FP_LAT < 1 || FP_LAT > 16) begin : g_bad_fp_lat
        $error("exe_mem: FP_LAT must be within 1..16");
    end

    localparam bit FP_MULTI = (FP_LAT > 1);

    logic     fp_start;
    logic     fp_busy;
    logic     fp_done;
    logic     fp_stall_req;
    mem_bus_t cap_bus;
    mem_bus_t bus_q, bus_d;

    // With FP_LAT==1 an FP op behaves exactly like an integer op.
    assign fp_start = bus.valid_EXE && bus.FP_EXE && FP_MULTI;

    exe_mem_fp_busy_ctr #(.FP_LAT(FP_LAT)) u_fp_ctr (
        .Clk         (Clk),
        .Rst         (Rst),
        .start_i     (fp_start),
        .flush_i     (bus.flush),
        .mem_stall_i (bus.mem_stall),
        .busy_o      (fp_busy),
        .done_o      (fp_done),
        .stall_req_o (fp_stall_req)
    );

    always_comb begin
        cap_bus            = '0;
        cap_bus.wb         = bus.WB_control_EXE;
        cap_bus.mem        = bus.MEM_control_EXE;
        cap_bus.pc         = bus.PC_EXE;
        cap_bus.result     = bus.FP_EXE ? bus.FP_result : bus.ALU_result;
        cap_bus.store_data = bus.Store_data;
        cap_bus.dst        = bus.Dst_reg;
        cap_bus.fp         = bus.FP_EXE;
        cap_bus.valid      = 1'b1;
    end

    always_comb begin
        bus_d = bus_q;
        if (!bus.mem_stall) begin
            if (bus.flush) begin
                bus_d = make_bubble(bus.PC_EXE);
            end else if (fp_busy) begin
                bus_d = fp_done ? cap_bus : make_bubble(bus.PC_EXE);
            end else if (bus.valid_EXE && !fp_start) begin
                bus_d = cap_bus;
            end else begin
                bus_d = make_bubble(bus.PC_EXE);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    assign bus.WB_control_MEM  = bus_q.wb;
    assign bus.MEM_control_MEM = bus_q.mem;
    assign bus.PC_MEM          = bus_q.pc;
    assign bus.Result_MEM      = bus_q.result;
    assign bus.Store_data_MEM  = bus_q.store_data;
    assign bus.Dst_reg_MEM     = bus_q.dst;
    assign bus.FP_MEM          = bus_q.fp;
    assign bus.valid_MEM       = bus_q.valid;
    assign bus.stall_EXE       = fp_stall_req || bus.mem_stall;

    // While busy, the FP result may only be latched on the final (cnt==0) cycle.
    a_fp_sample_at_done: assert property (@(posedge Clk) disable iff (Rst)
        (fp_busy && !bus.mem_stall && !bus.flush && bus_d.valid) |-> fp_done);

endmodule
